squash_arbiter: RTL and testbench

SQUASH_ARBITER -- requirements
Module: squash_arbiter

---
 rtl/squash_arbiter.sv | 97 +++++++++
 tb/tb_squash_arbiter.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/squash_arbiter.sv
// Squash arbiter: picks the oldest eligible squash request and
// emits a one-cycle redirect pulse. Younger squashes are filtered while ACTIVE.
module squash_arbiter #(
   parameter int p_seq_num_bits = 5,
   parameter int p_num_req      = 2
) (
   input  logic                                clk,
   input  logic                                rst,
   input  logic [p_num_req-1:0]                req_val,
   input  logic [p_num_req*p_seq_num_bits-1:0] req_seq_num,
   input  logic [p_num_req*32-1:0]             req_target,
   input  logic [p_seq_num_bits-1:0]           head_seq_num,
   input  logic                                commit_val,
   input  logic [p_seq_num_bits-1:0]           commit_seq_num,
   output logic                                squash_val,
   output logic [p_seq_num_bits-1:0]           squash_seq_num,
   output logic [31:0]                         squash_target,
   output logic                                busy
);

   localparam int W = p_seq_num_bits;

   typedef enum logic {IDLE, ACTIVE} state_t;

   state_t         state_q;
   logic [W-1:0]   active_seq_q;
   logic           squash_val_q;
   logic [W-1:0]   squash_seq_q;
   logic [31:0]    squash_tgt_q;
   logic           busy_q;

   logic           sel_found;
   logic [W-1:0]   sel_age;
   logic [W-1:0]   sel_seq;
   logic [31:0]    sel_tgt;
   logic [W-1:0]   active_age;
   logic [W-1:0]   req_seq;
   logic [W-1:0]   req_age;
   logic           elig;

   // Modular distance from head; wrap-around handled by W-bit subtraction.
   assign active_age = active_seq_q - head_seq_num;

   always_comb begin
      sel_found = 1'b0;
      sel_age   = '0;
      sel_seq   = '0;
      sel_tgt   = '0;
      req_seq   = '0;
      req_age   = '0;
      elig      = 1'b0;
      for (int i = 0; i < p_num_req; i++) begin
         req_seq = req_seq_num[i*W +: W];
         req_age = req_seq - head_seq_num;
         elig    = req_val[i] &&
                   ((state_q == IDLE) || (req_age < active_age));
         // Strict compare keeps the lowest index on ties.
         if (elig && (!sel_found || (req_age < sel_age))) begin
            sel_found = 1'b1;
            sel_age   = req_age;
            sel_seq   = req_seq;
            sel_tgt   = req_target[i*32 +: 32];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q      <= IDLE;
         active_seq_q <= '0;
         squash_val_q <= 1'b0;
         squash_seq_q <= '0;
         squash_tgt_q <= '0;
         busy_q       <= 1'b0;
      end else if (sel_found) begin
         state_q      <= ACTIVE;
         active_seq_q <= sel_seq;
         squash_val_q <= 1'b1;
         squash_seq_q <= sel_seq;
         squash_tgt_q <= sel_tgt;
         busy_q       <= 1'b1;
      end else begin
         squash_val_q <= 1'b0;
         if ((state_q == ACTIVE) && commit_val &&
             (commit_seq_num == active_seq_q)) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
         end
      end
   end

   assign squash_val     = squash_val_q;
   assign squash_seq_num = squash_seq_q;
   assign squash_target  = squash_tgt_q;
   assign busy           = busy_q;

endmodule

// File: tb/tb_squash_arbiter.sv
// Bench for squash_arbiter: directed scenarios then random traffic,
// checked against an age-based reference model.
module tb_squash_arbiter;

   localparam int W = 5;
   localparam int N = 2;
   localparam int M = 32;

   logic             clk;
   logic             rst;
   logic [N-1:0]     req_val;
   logic [N*W-1:0]   req_seq_num;
   logic [N*32-1:0]  req_target;
   logic [W-1:0]     head_seq_num;
   logic             commit_val;
   logic [W-1:0]     commit_seq_num;
   logic             squash_val;
   logic [W-1:0]     squash_seq_num;
   logic [31:0]      squash_target;
   logic             busy;

   int total = 0;
   int bad   = 0;

   bit m_active;
   int m_seq;
   bit m_sv;
   int m_sseq;
   int m_stgt;

   squash_arbiter #(.p_seq_num_bits(W), .p_num_req(N)) dut (
      .clk            (clk),
      .rst            (rst),
      .req_val        (req_val),
      .req_seq_num    (req_seq_num),
      .req_target     (req_target),
      .head_seq_num   (head_seq_num),
      .commit_val     (commit_val),
      .commit_seq_num (commit_seq_num),
      .squash_val     (squash_val),
      .squash_seq_num (squash_seq_num),
      .squash_target  (squash_target),
      .busy           (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic int age(input int x, input int h);
      return ((x - h) % M + M) % M;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
      end
   endtask

   task automatic clr();
      req_val        = '0;
      req_seq_num    = '0;
      req_target     = '0;
      commit_val     = 1'b0;
      commit_seq_num = '0;
   endtask

   task automatic set_req(input int i, input int s, input int t);
      req_val[i]           = 1'b1;
      req_seq_num[i*W +: W] = W'(s);
      req_target[i*32 +: 32] = 32'(t);
   endtask

   task automatic commit(input int s);
      commit_val     = 1'b1;
      commit_seq_num = W'(s);
   endtask

   // Reference: oldest eligible request wins, otherwise a matching commit retires.
   task automatic model_step();
      int h, best, best_age, a, s;
      h = int'(head_seq_num);
      if (!rst) begin
         m_active = 0; m_seq = 0; m_sv = 0; m_sseq = 0; m_stgt = 0;
         return;
      end
      best = -1;
      best_age = M;
      for (int i = 0; i < N; i++) begin
         s = int'(req_seq_num[i*W +: W]);
         a = age(s, h);
         if (req_val[i] && (!m_active || a < age(m_seq, h)) && a < best_age) begin
            best = i;
            best_age = a;
         end
      end
      if (best >= 0) begin
         m_sv     = 1;
         m_sseq   = int'(req_seq_num[best*W +: W]);
         m_stgt   = int'(req_target[best*32 +: 32]);
         m_active = 1;
         m_seq    = m_sseq;
      end else begin
         m_sv = 0;
         if (m_active && commit_val && int'(commit_seq_num) == m_seq)
            m_active = 0;
      end
   endtask

   task automatic cycle(input string tag);
      model_step();
      @(posedge clk);
      #1;
      chk({tag, ".val"}, 32'(squash_val), 32'(m_sv));
      chk({tag, ".seq"}, 32'(squash_seq_num), 32'(m_sseq));
      chk({tag, ".tgt"}, squash_target, 32'(m_stgt));
      chk({tag, ".busy"}, 32'(busy), 32'(m_active));
      clr();
   endtask

   task automatic do_reset();
      clr();
      rst = 1'b0;
      cycle("rst");
      rst = 1'b1;
   endtask

   initial begin
      rst = 1'b0;
      head_seq_num = '0;
      clr();
      @(posedge clk);
      #1;
      cycle("rst0");
      chk("rst0.busy_c", 32'(busy), 32'd0);
      rst = 1'b1;

      set_req(0, 3, 'h100);
      cycle("r31a");
      chk("r31a.seq_c", 32'(squash_seq_num), 32'd3);
      chk("r31a.busy_c", 32'(busy), 32'd1);
      cycle("r31b");
      chk("r31b.val_c", 32'(squash_val), 32'd0);
      commit(3);
      cycle("r31c");

      set_req(0, 7, 'h200);
      set_req(1, 4, 'h300);
      cycle("r32a");
      chk("r32a.tgt_c", squash_target, 32'h300);
      do_reset();
      set_req(0, 4, 'hA);
      set_req(1, 4, 'hB);
      cycle("r32tie");
      chk("r32tie.tgt_c", squash_target, 32'hA);

      set_req(0, 9, 'h900);
      cycle("r33y");
      set_req(1, 4, 'h444);
      cycle("r33eq");
      chk("r33eq.val_c", 32'(squash_val), 32'd0);
      set_req(1, 2, 'h40);
      cycle("r33o");
      chk("r33o.seq_c", 32'(squash_seq_num), 32'd2);

      do_reset();
      head_seq_num = 5'd30;
      set_req(0, 1, 'h11);
      set_req(1, 31, 'h31);
      cycle("r34a");
      chk("r34a.seq_c", 32'(squash_seq_num), 32'd31);
      set_req(0, 1, 'h11);
      cycle("r34b");
      chk("r34b.val_c", 32'(squash_val), 32'd0);
      head_seq_num = '0;

      do_reset();
      set_req(0, 4, 'h4);
      cycle("r35a");
      commit(5);
      cycle("r35b");
      chk("r35b.busy_c", 32'(busy), 32'd1);
      commit(4);
      cycle("r35c");
      chk("r35c.busy_c", 32'(busy), 32'd0);
      set_req(1, 9, 'h99);
      cycle("r35d");
      chk("r35d.seq_c", 32'(squash_seq_num), 32'd9);
      do_reset();
      set_req(0, 4, 'h4);
      cycle("r35e");
      commit(4);
      set_req(0, 9, 'h99);
      cycle("r35f");
      chk("r35f.busy_c", 32'(busy), 32'd0);

      set_req(0, 6, 'h66);
      cycle("r36a");
      rst = 1'b0;
      set_req(0, 1, 'h1);
      cycle("r36b");
      chk("r36b.tgt_c", squash_target, 32'd0);
      rst = 1'b1;
      set_req(0, 20, 'h20);
      cycle("r36c");
      chk("r36c.seq_c", 32'(squash_seq_num), 32'd20);

      for (int k = 0; k < 400; k++) begin
         head_seq_num = W'($urandom_range(0, M - 1));
         for (int i = 0; i < N; i++)
            if ($urandom_range(0, 2) != 0)
               set_req(i, int'($urandom_range(0, M - 1)), int'($urandom));
         if ($urandom_range(0, 3) == 0)
            commit(($urandom_range(0, 1) == 0) ? m_seq
                   : int'($urandom_range(0, M - 1)));
         rst = ($urandom_range(0, 40) == 0) ? 1'b0 : 1'b1;
         cycle("rnd");
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
